// File: rtl/vend_pkg.sv
// Shared definitions for the parametrised vending controller.
//   vend_state_e  : 2-bit FSM state encoding (IDLE/COLLECT/DISPENSE/REFUND)
//   DEF_*         : default parameter values used by the top and its interface
//   order_ok()    : legal-order check (ball count in range and affordable)
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        REFUND   = 2'd3
    } vend_state_e;

    localparam int DEF_COIN_W     = 2;
    localparam int DEF_CREDIT_W   = 4;
    localparam int DEF_CREDIT_MAX = 15;
    localparam int DEF_PRICE      = 2;
    localparam int DEF_BALL_W     = 2;
    localparam int DEF_MAX_BALLS  = 3;

    // cost is computed by the caller at full width (balls * price), so no
    // overflow can make an unaffordable order look cheap.
    function automatic logic order_ok(input int balls, input int cost,
                                      input int credit, input int max_balls);
        return (balls >= 1) && (balls <= max_balls) && (cost <= credit);
    endfunction

endpackage

// File: rtl/vend_fsm_param_if.sv
// Bus between the vending controller and its front/back ends.
//   Inputs to the controller : coin_valid/coin_value, order_valid/order_balls,
//                              cancel, out_ready, change_ready
//   Outputs of the controller: state, credit, coin_reject, order_nack,
//                              out_valid/out_balls, change_valid/change_amount
// Handshakes: out_valid/out_balls and change_valid/change_amount are held
// stable until the matching ready is seen high in the same cycle as valid;
// the transfer completes on that clock edge.
interface vend_fsm_param_if
    import vend_pkg::*;
#(
    parameter int COIN_W   = DEF_COIN_W,
    parameter int CREDIT_W = DEF_CREDIT_W,
    parameter int BALL_W   = DEF_BALL_W
);
    logic                coin_valid;
    logic [COIN_W-1:0]   coin_value;
    logic                order_valid;
    logic [BALL_W-1:0]   order_balls;
    logic                cancel;
    logic                out_ready;
    logic                change_ready;
    vend_state_e         state;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                order_nack;
    logic                out_valid;
    logic [BALL_W-1:0]   out_balls;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amount;

    modport slave (
        input  coin_valid, coin_value, order_valid, order_balls, cancel,
               out_ready, change_ready,
        output state, credit, coin_reject, order_nack, out_valid, out_balls,
               change_valid, change_amount
    );

    modport master (
        output coin_valid, coin_value, order_valid, order_balls, cancel,
               out_ready, change_ready,
        input  state, credit, coin_reject, order_nack, out_valid, out_balls,
               change_valid, change_amount
    );
endinterface

// File: rtl/vend_credit_acc.sv
// Credit register with subtract, add-with-ceiling and clear.
//   clk, reset            : clock, synchronous active-high reset
//   add_en/add_value      : coin to add (applied after any subtract)
//   sub_en/sub_value      : order cost to take off (caller ensures <= credit)
//   clear                 : zero the credit (overrides add/subtract)
//   credit                : registered credit
//   credit_next           : value credit takes on the next edge
//   reject                : add would exceed CREDIT_MAX; credit keeps base value
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int COIN_W     = DEF_COIN_W,
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int CREDIT_MAX = DEF_CREDIT_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                add_en,
    input  logic [COIN_W-1:0]   add_value,
    input  logic                sub_en,
    input  logic [CREDIT_W-1:0] sub_value,
    input  logic                clear,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] credit_next,
    output logic                reject
);
    logic [CREDIT_W-1:0] base;
    logic [CREDIT_W:0]   sum;

    always_comb begin
        base = sub_en ? (credit - sub_value) : credit;
        // One extra bit so the ceiling test cannot be fooled by wrap-around.
        sum    = {1'b0, base} + (CREDIT_W+1)'(add_value);
        reject = add_en && (sum > (CREDIT_W+1)'(CREDIT_MAX));
        if (clear) begin
            credit_next = '0;
        end else if (add_en && !reject) begin
            credit_next = sum[CREDIT_W-1:0];
        end else begin
            credit_next = base;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit <= '0;
        end else begin
            credit <= credit_next;
        end
    end
endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: accumulates coin credit, takes multi-ball
// orders at PRICE units per ball, dispenses via out_valid/out_ready, refunds
// via change_valid/change_ready, keeps leftover credit between orders.
//   clk, reset : clock, synchronous active-high reset
//   bus        : vend_fsm_param_if slave modport (coins, orders, cancel,
//                both handshakes, state/credit/pulse outputs)
// Every output is a register; no input reaches an output combinationally.
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int COIN_W     = DEF_COIN_W,
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int CREDIT_MAX = DEF_CREDIT_MAX,
    parameter int PRICE      = DEF_PRICE,
    parameter int BALL_W     = DEF_BALL_W,
    parameter int MAX_BALLS  = DEF_MAX_BALLS
) (
    input logic             clk,
    input logic             reset,
    vend_fsm_param_if.slave bus
);
    localparam int COST_W = CREDIT_W + BALL_W;

    vend_state_e         state_q, state_n;
    logic                coin_reject_q, coin_reject_n;
    logic                order_nack_q, order_nack_n;
    logic                out_valid_q, out_valid_n;
    logic [BALL_W-1:0]   out_balls_q, out_balls_n;
    logic                change_valid_q, change_valid_n;
    logic [CREDIT_W-1:0] change_amount_q, change_amount_n;
    logic                cancel_pend_q, cancel_pend_n;

    logic                add_en, sub_en, clear, acc_reject, order_legal;
    logic [CREDIT_W-1:0] credit_q, credit_next;
    logic [COST_W-1:0]   cost;

    assign cost        = COST_W'(bus.order_balls) * COST_W'(PRICE);
    assign order_legal = order_ok(int'(bus.order_balls), int'(cost),
                                  int'(credit_q), MAX_BALLS);

    vend_credit_acc #(
        .COIN_W     (COIN_W),
        .CREDIT_W   (CREDIT_W),
        .CREDIT_MAX (CREDIT_MAX)
    ) u_acc (
        .clk         (clk),
        .reset       (reset),
        .add_en      (add_en),
        .add_value   (bus.coin_value),
        .sub_en      (sub_en),
        .sub_value   (cost[CREDIT_W-1:0]),
        .clear       (clear),
        .credit      (credit_q),
        .credit_next (credit_next),
        .reject      (acc_reject)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            coin_reject_q   <= 1'b0;
            order_nack_q    <= 1'b0;
            out_valid_q     <= 1'b0;
            out_balls_q     <= '0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            cancel_pend_q   <= 1'b0;
        end else begin
            state_q         <= state_n;
            coin_reject_q   <= coin_reject_n;
            order_nack_q    <= order_nack_n;
            out_valid_q     <= out_valid_n;
            out_balls_q     <= out_balls_n;
            change_valid_q  <= change_valid_n;
            change_amount_q <= change_amount_n;
            cancel_pend_q   <= cancel_pend_n;
        end
    end

    always_comb begin
        state_n         = state_q;
        coin_reject_n   = 1'b0;
        order_nack_n    = 1'b0;
        out_valid_n     = out_valid_q;
        out_balls_n     = out_balls_q;
        change_valid_n  = change_valid_q;
        change_amount_n = change_amount_q;
        cancel_pend_n   = cancel_pend_q;
        add_en          = 1'b0;
        sub_en          = 1'b0;
        clear           = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if (bus.cancel && state_q == COLLECT) begin
                    // Refund snapshots current credit; a coin arriving in
                    // the same cycle is handed straight back.
                    state_n         = REFUND;
                    change_valid_n  = 1'b1;
                    change_amount_n = credit_q;
                    coin_reject_n   = bus.coin_valid;
                end else begin
                    add_en = bus.coin_valid;
                    // cancel outranks order; in IDLE it only drops the order.
                    if (bus.order_valid && !bus.cancel) begin
                        if (order_legal) begin
                            sub_en      = 1'b1;
                            out_valid_n = 1'b1;
                            out_balls_n = bus.order_balls;
                        end else begin
                            order_nack_n = 1'b1;
                        end
                    end
                    coin_reject_n = acc_reject;
                    if (sub_en) begin
                        state_n = DISPENSE;
                    end else begin
                        state_n = (credit_next != '0) ? COLLECT : IDLE;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_n = bus.coin_valid;
                if (bus.cancel) begin
                    cancel_pend_n = 1'b1;
                end
                if (bus.out_ready) begin
                    out_valid_n   = 1'b0;
                    out_balls_n   = '0;
                    cancel_pend_n = 1'b0;
                    if ((cancel_pend_q || bus.cancel) && credit_q != '0) begin
                        state_n         = REFUND;
                        change_valid_n  = 1'b1;
                        change_amount_n = credit_q;
                    end else begin
                        state_n = (credit_q != '0) ? COLLECT : IDLE;
                    end
                end
            end
            REFUND: begin
                coin_reject_n = bus.coin_valid;
                if (bus.change_ready) begin
                    change_valid_n  = 1'b0;
                    change_amount_n = '0;
                    clear           = 1'b1;
                    state_n         = IDLE;
                end
            end
        endcase
    end

    assign bus.state         = state_q;
    assign bus.credit        = credit_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.order_nack    = order_nack_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_balls     = out_balls_q;
    assign bus.change_valid  = change_valid_q;
    assign bus.change_amount = change_amount_q;
endmodule
